// File: rtl/out_port_sequencer.sv
// Round-robin arbiter that serialises masked byte writes from two requesters
// into single-bit writes on the bit-addressable output selector.
module out_port_sequencer #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [WIDTH-1:0]  byte_a,
  input  logic [WIDTH-1:0]  mask_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [WIDTH-1:0]  byte_b,
  input  logic [WIDTH-1:0]  mask_b,
  output logic              ack_b,
  input  logic              lock,
  output logic              sel_data,
  output logic [ADDR_W-1:0] sel_addr,
  output logic              sel_write,
  output logic              sel_ce,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH - 1);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic              prio_r, prio_s;   // 0 = A has priority, 1 = B
  logic              gnt_r, gnt_s;     // 0 = A granted, 1 = B granted
  logic              pick_b_s;
  logic [WIDTH-1:0]  byte_r, byte_s;
  logic [WIDTH-1:0]  mask_r, mask_s;

  logic              sel_data_r, sel_data_s;
  logic [ADDR_W-1:0] sel_addr_r, sel_addr_s;
  logic              sel_write_r, sel_write_s;
  logic              sel_ce_r, sel_ce_s;
  logic              ack_a_r, ack_a_s;
  logic              ack_b_r, ack_b_s;
  logic              busy_r;

  // Next-state, arbitration and next-output logic
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    prio_s      = prio_r;
    gnt_s       = gnt_r;
    byte_s      = byte_r;
    mask_s      = mask_r;
    pick_b_s    = 1'b0;
    sel_data_s  = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_write_s = 1'b0;
    sel_ce_s    = 1'b0;
    ack_a_s     = 1'b0;
    ack_b_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_a || req_b) begin
          pick_b_s = req_b & (~req_a | prio_r);
          gnt_s    = pick_b_s;
          prio_s   = ~pick_b_s;
          byte_s   = pick_b_s ? byte_b : byte_a;
          mask_s   = pick_b_s ? mask_b : mask_a;
          idx_s    = {ADDR_W{1'b0}};
          state_s  = SHIFT;
        end else begin
          state_s  = IDLE;
        end
      end
      SHIFT: begin
        // A locked cycle still presents the bit but suppresses the strobe
        sel_ce_s    = 1'b1;
        sel_addr_s  = idx_r;
        sel_data_s  = byte_r[idx_r];
        sel_write_s = mask_r[idx_r] & ~lock;
        if (lock) begin
          idx_s   = idx_r;
          state_s = SHIFT;
        end else if (idx_r == LAST_IDX) begin
          idx_s   = {ADDR_W{1'b0}};
          state_s = DONE;
        end else begin
          idx_s   = idx_r + ADDR_W'(1);
          state_s = SHIFT;
        end
      end
      DONE: begin
        ack_a_s = ~gnt_r;
        ack_b_s = gnt_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= {ADDR_W{1'b0}};
      prio_r      <= 1'b0;
      gnt_r       <= 1'b0;
      byte_r      <= {WIDTH{1'b0}};
      mask_r      <= {WIDTH{1'b0}};
      sel_data_r  <= 1'b0;
      sel_addr_r  <= {ADDR_W{1'b0}};
      sel_write_r <= 1'b0;
      sel_ce_r    <= 1'b0;
      ack_a_r     <= 1'b0;
      ack_b_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      prio_r      <= prio_s;
      gnt_r       <= gnt_s;
      byte_r      <= byte_s;
      mask_r      <= mask_s;
      sel_data_r  <= sel_data_s;
      sel_addr_r  <= sel_addr_s;
      sel_write_r <= sel_write_s;
      sel_ce_r    <= sel_ce_s;
      ack_a_r     <= ack_a_s;
      ack_b_r     <= ack_b_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign sel_data  = sel_data_r;
  assign sel_addr  = sel_addr_r;
  assign sel_write = sel_write_r;
  assign sel_ce    = sel_ce_r;
  assign ack_a     = ack_a_r;
  assign ack_b     = ack_b_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_out_port_sequencer.sv
// Self-checking bench for out_port_sequencer: directed scenarios plus randomized
// transactions checked against a latch-image and timing reference model.
module tb_out_port_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req_a, req_b, lock;
  logic [7:0] byte_a, byte_b, mask_a, mask_b;
  logic       ack_a, ack_b, sel_data, sel_write, sel_ce, busy;
  logic [2:0] sel_addr;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] img;        // latch image rebuilt from selector strobes
  logic [7:0] model_img;  // expected latch contents
  bit         prio_m;     // 0 = A next on contention

  out_port_sequencer #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .byte_a(byte_a), .mask_a(mask_a), .ack_a(ack_a),
    .req_b(req_b), .byte_b(byte_b), .mask_b(mask_b), .ack_b(ack_b),
    .lock(lock),
    .sel_data(sel_data), .sel_addr(sel_addr), .sel_write(sel_write),
    .sel_ce(sel_ce), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and record any selector write
  task automatic tick();
    @(negedge clk);
    if (sel_ce && sel_write) img[sel_addr] = sel_data;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; lock = 1'b0;
    tick(); tick();
    rst = 1'b0;
    img = 8'h00; model_img = 8'h00; prio_m = 1'b0;
  endtask

  task automatic check_outs(input string tag, input bit ce, input int addr, input bit data,
                            input bit wr, input bit aa, input bit ab, input bit bz);
    chk({tag, "_ce"},   32'(sel_ce),    32'(ce));
    chk({tag, "_addr"}, 32'(sel_addr),  32'(addr));
    chk({tag, "_data"}, 32'(sel_data),  32'(data));
    chk({tag, "_wr"},   32'(sel_write), 32'(wr));
    chk({tag, "_acka"}, 32'(ack_a),     32'(aa));
    chk({tag, "_ackb"}, 32'(ack_b),     32'(ab));
    chk({tag, "_busy"}, 32'(busy),      32'(bz));
  endtask

  // Single unlocked transaction from one requester, checked every cycle
  task automatic run_plain(input string tag, input bit who, input logic [7:0] b, input logic [7:0] m);
    if (who) begin byte_b = b; mask_b = m; req_b = 1'b1; end
    else     begin byte_a = b; mask_a = m; req_a = 1'b1; end
    for (int k = 0; k < 10; k++) begin
      bit ce;
      int bi;
      tick();
      ce = (k >= 1) && (k <= 8);
      bi = ce ? k - 1 : 0;
      check_outs($sformatf("%s_c%0d", tag, k), ce, bi, ce & b[bi], ce & m[bi],
                 (k == 9) && !who, (k == 9) && who, k <= 8);
      if (k == 9) begin req_a = 1'b0; req_b = 1'b0; end
    end
    model_img = (model_img & ~m) | (b & m);
    chk({tag, "_img"}, 32'(img), 32'(model_img));
    prio_m = !who;
  endtask

  initial begin
    int  ack_cyc[$];
    bit  ack_who[$];
    bit  seen;

    byte_a = 8'h00; byte_b = 8'h00; mask_a = 8'h00; mask_b = 8'h00;
    do_reset();
    check_outs("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_plain("basic", 1'b0, 8'hA5, 8'hFF);
    run_plain("mask",  1'b1, 8'hFF, 8'h81);
    run_plain("zero",  1'b0, 8'h5A, 8'h00);

    // Lock held for three cycles while bit 4 is presented
    byte_a = 8'hA5; mask_a = 8'hFF; req_a = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k >= 5 && k <= 7) begin
        chk($sformatf("lock_c%0d_addr", k), 32'(sel_addr),  32'd4);
        chk($sformatf("lock_c%0d_wr", k),   32'(sel_write), 32'd0);
        chk($sformatf("lock_c%0d_ce", k),   32'(sel_ce),    32'd1);
      end
      if (k == 8) begin
        chk("lock_rel_addr", 32'(sel_addr),  32'd4);
        chk("lock_rel_wr",   32'(sel_write), 32'd1);
        chk("lock_rel_data", 32'(sel_data),  32'd0);
      end
      if (k == 11) begin
        chk("lock_bit7_addr", 32'(sel_addr), 32'd7);
        chk("lock_noack11",   32'(ack_a),    32'd0);
      end
      if (k == 12) begin
        chk("lock_ack12", 32'(ack_a), 32'd1);
        req_a = 1'b0;
      end
      if (k == 4) lock = 1'b1;
      if (k == 7) lock = 1'b0;
    end
    model_img = (model_img & ~8'hFF) | (8'hA5 & 8'hFF);
    chk("lock_img", 32'(img), 32'(model_img));
    prio_m = 1'b1;

    // Reset in the middle of a transfer
    byte_a = 8'h3C; mask_a = 8'hFF; req_a = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1; req_a = 1'b0;
    tick();
    check_outs("rstmid", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    img = 8'h00; model_img = 8'h00; prio_m = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      seen = seen | ack_a | ack_b;
    end
    chk("rstmid_noack", 32'(seen), 32'd0);

    // Contention right after reset: A first, then alternation
    byte_a = 8'h0F; mask_a = 8'hFF; byte_b = 8'hF0; mask_b = 8'h3C;
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ack_a) begin ack_cyc.push_back(c); ack_who.push_back(1'b0); end
      if (ack_b) begin ack_cyc.push_back(c); ack_who.push_back(1'b1); end
      if (c == 29) req_a = 1'b0;
      if (c == 39) req_b = 1'b0;
    end
    chk("arb_count", 32'(ack_cyc.size()), 32'd4);
    for (int i = 0; i < ack_cyc.size() && i < 4; i++) begin
      chk($sformatf("arb_cyc%0d", i), 32'(ack_cyc[i]), 32'(9 + 10 * i));
      chk($sformatf("arb_who%0d", i), 32'(ack_who[i]), 32'(i % 2));
    end
    model_img = (model_img & ~8'hFF) | (8'h0F & 8'hFF);
    model_img = (model_img & ~8'h3C) | (8'hF0 & 8'h3C);
    chk("arb_img", 32'(img), 32'(model_img));
    prio_m = 1'b0;

    // Randomized transactions with random lock stalls
    for (int t = 0; t < 40; t++) begin
      bit         ra, rb, who, done;
      int         sel, left, stalls;
      logic [7:0] cb, cm;
      if ($urandom_range(0, 3) == 0) begin
        req_a = 1'b0; req_b = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      sel = $urandom_range(0, 2);
      ra = (sel != 1); rb = (sel != 0);
      byte_a = 8'($urandom); mask_a = 8'($urandom);
      byte_b = 8'($urandom); mask_b = 8'($urandom);
      who = (ra && rb) ? prio_m : rb;
      cb = who ? byte_b : byte_a;
      cm = who ? mask_b : mask_a;
      req_a = ra; req_b = rb;
      lock = ($urandom_range(0, 1) == 0);
      left = 8; stalls = 0; done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
        tick();
        if (ack_a || ack_b) begin
          chk($sformatf("rnd%0d_ackcyc", t), 32'(k), 32'(9 + stalls));
          chk($sformatf("rnd%0d_acka", t), 32'(ack_a), 32'(!who));
          chk($sformatf("rnd%0d_ackb", t), 32'(ack_b), 32'(who));
          chk($sformatf("rnd%0d_busy", t), 32'(busy), 32'd0);
          model_img = (model_img & ~cm) | (cb & cm);
          chk($sformatf("rnd%0d_img", t), 32'(img), 32'(model_img));
          prio_m = !who;
          req_a = 1'b0; req_b = 1'b0;
          done = 1'b1;
        end else begin
          if (k == 0) begin
            byte_a = 8'($urandom); mask_a = 8'($urandom);
            byte_b = 8'($urandom); mask_b = 8'($urandom);
          end
          lock = ($urandom_range(0, 3) == 0);
          if (left > 0) begin
            if (lock) stalls++;
            else      left--;
          end
        end
      end
      if (!done) chk($sformatf("rnd%0d_timeout", t), 32'd0, 32'd1);
    end
    lock = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/out_port_sequencer.md
# out_port_sequencer

Sequencer and arbiter for the processor's bit-addressable output latch (output selector). It accepts whole-byte, bit-masked output writes from two requesters: A, the CPU core, and B, the debug/DMA port. It grants one request at a time, round-robin, and serialises the granted byte into eight single-bit writes on the selector's `data`/`addr`/`write`/`CE` inputs, one bit per clock. Requesters therefore never drive the selector directly.

## Interface
Parameters:
- `WIDTH`, default 8: latch width in bits; must equal 2^`ADDR_W`.
- `ADDR_W`, default 3: selector bit-address width.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_a`  in  1  requester A write request; held high until `ack_a`.
- `byte_a`  in  WIDTH  requester A data.
- `mask_a`  in  WIDTH  requester A bit-enable; 1 = update that bit.
- `ack_a`  out  1  one-cycle completion pulse to A.
- `req_b`, `byte_b`, `mask_b`, `ack_b`: same as the A ports, for requester B.
- `lock`  in  1  write lock; the same signal that drives the selector's `writeDisable`.
- `sel_data`  out  1  bit value to the selector `data` input.
- `sel_addr`  out  ADDR_W  bit index to the selector `addr` input.
- `sel_write`  out  1  selector `write` strobe.
- `sel_ce`  out  1  selector `CE`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If any `req_*` is high, grant one requester, then go to SHIFT with `idx`=0.
  - Capture that requester's byte and mask into internal registers.
  - Store the granted requester's ID.
- Arbitration: round-robin pointer `prio`, reset to A.
  - If both requesters request, the one named by `prio` wins.
  - If only one requests, it wins.
  - After every grant, `prio` points to the requester that was not granted.
- SHIFT, each cycle:
  - `sel_ce`=1, `sel_addr`=`idx`, `sel_data`=captured byte[`idx`].
  - `sel_write` = captured mask[`idx`] & ~`lock`.
  - If `lock`=0, `idx` increments. If `lock`=1, `idx` holds and `sel_write`=0 (the bit is retried).
  - When `lock`=0 and `idx`=WIDTH-1, go to DONE.
- Masked-out bits still take one cycle with `sel_write`=0. Latency is therefore fixed and independent of the mask.
- DONE: pulse the granted requester's `ack_*` for exactly one cycle, with `sel_ce`=`sel_write`=0. Then go to IDLE.
- Request inputs are ignored outside IDLE. Byte and mask may change after grant without effect.
- A requester must drop `req_*` in the cycle `ack_*` is seen, or it is treated as a new request in the following IDLE cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Timing
- Reset values:
  - state IDLE, `prio`=A, `idx`=0.
  - `ack_a`, `ack_b`, `sel_data`, `sel_write`, `sel_ce`, `busy` = 0; `sel_addr`=0.
- Reset while in SHIFT or DONE:
  - Return to IDLE next edge; no ack is issued and the transaction is abandoned.
  - Bits already written are not rolled back; the shared `rst` clears the latch anyway.
- Unlocked transaction, with grant at edge 0:
  - First selector write (bit 0) is visible in cycle 1.
  - Bit 7 is visible in cycle 8.
  - `ack` is visible in cycle 9.
  - The earliest next grant is at edge 10.
  - Total: 10 cycles per transaction.
- Each lock cycle during SHIFT adds exactly one cycle. `lock` in IDLE or DONE has no effect.
- Simultaneous `req_a` and `req_b` in the same cycle: resolved solely by `prio`. There is no starvation: the maximum wait is one transaction.
- `mask`=0: the full 10-cycle sequence runs with no `sel_write` pulse, and `ack` is still issued.

## Test plan
- Basic write:
  - Stimulus: after reset, `req_a` with `byte_a`=8'hA5, `mask_a`=8'hFF.
  - Response: over cycles 1–8, `sel_write`=1 with `sel_addr` 0..7 and `sel_data` 1,0,1,0,0,1,0,1; `ack_a` high only in cycle 9.
- Masking:
  - Stimulus: `byte_b`=8'hFF, `mask_b`=8'h81.
  - Response: `sel_write` high only at `sel_addr` 0 and 7; `ack_b` at cycle 9.
- Arbitration:
  - Stimulus: `req_a` and `req_b` asserted together and held, re-requesting after each ack.
  - Response: grants alternate A, B, A, B with 10-cycle spacing; a lone `req_b` after an A grant is served immediately.
- Lock:
  - Stimulus: `lock` high for 3 cycles while `idx`=4.
  - Response: `sel_addr` holds at 4 with `sel_write`=0 for 3 cycles; bit 4 is written on release; `ack` is at cycle 12.
- Reset mid-transfer:
  - Stimulus: `rst` at cycle 5 of a transaction.
  - Response: next cycle `busy`=0, no ack, `prio`=A, all `sel_*` outputs are 0.
- Zero mask:
  - Stimulus: `mask_a`=8'h00.
  - Response: no `sel_write` pulses; `sel_ce`=1 in cycles 1–8; `ack_a` at cycle 9.
